comparatore_seq: RTL and testbench
==================================

// Module: comparatore_seq
// PURPOSE
//  Multi-cycle magnitude comparator for WIDTH-bit operands, unsigned or two's-complement.
//  Scans DIGIT bits per cycle, MSB-first, and reports one-hot GT/EQ/LT.
//  Uses valid/ready handshakes on input and output.
//  Serves datapaths where a full-width combinational compare would break timing.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of DIGIT
//  DIGIT  4   bits compared per scan cycle; NDIG = WIDTH/DIGIT digits in total
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operands and mode are valid
//  in_ready     out  1      block accepts operands (high only in IDLE)
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  signed_mode  in   1      1 = two's-complement compare, 0 = unsigned
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  gt / eq / lt out  1 each one-hot result: A>B / A==B / A<B
//  busy         out  1      high in SCAN and DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, gt=eq=lt=0, busy=0, digit index=NDIG-1.
//  - FSM states: IDLE, SCAN, DONE.
//  - IDLE: in_valid & in_ready at edge k -> capture a, b, signed_mode; go to SCAN.
//  - Signed capture: when signed_mode=1, invert the MSB of both captured operands (offset binary).
//    An unsigned scan then gives the signed order.
//  - SCAN: each edge compares digit[idx] of A and B and decrements idx.
//    The first unequal digit sets a sticky result: GT if a_d>b_d, LT if a_d<b_d.
//    If no digit differs, the result is EQ.
//  - Without EARLY_EXIT_EN: SCAN always lasts NDIG edges.
//    Result registered at edge k+NDIG; out_valid=1 from then on.
//  - DONE: out_valid=1; gt/eq/lt held stable; in_ready=0; in_valid is ignored.
//    out_valid & out_ready at an edge -> clear out_valid/gt/eq/lt, go to IDLE.
//  - No result bypass: minimum period between accepts is NDIG+2 cycles (accept, SCAN, DONE).
//  - Result rules: exactly one of gt/eq/lt is high whenever out_valid=1; all are 0 otherwise.
//  - Input capture: after the accept edge, changes on a/b/signed_mode have no effect.
//  - Reset mid-operation (SCAN or DONE): the operation is aborted and no result is produced.
//    All outputs go to their reset values immediately.
//  - Elaboration error if WIDTH%DIGIT != 0 or DIGIT < 1.
// CONFIGURATION
//  Macro COMPARATORE_EARLY_EXIT_EN:
//  - Defined: SCAN ends on the edge that finds the first differing digit.
//    Latency j = 1-based position of that digit counted from the MSB (j = NDIG when equal).
//    out_valid is set at edge k+j.
//  - Undefined: fixed latency NDIG. Results are identical in both builds; only timing differs.
// STRUCTURE
//  - comparatore_pkg:
//    - state_t enum {IDLE, SCAN, DONE}
//    - cmp_res_t one-hot encoding {GT=3'b100, EQ=3'b010, LT=3'b001}
//    - function cmp_digit_res() combining a sticky result with a new digit result
//  - Sub-module comparatore_digit #(DIGIT):
//    - combinational compare of one DIGIT-bit slice -> gt/eq/lt
//    - DIGIT-wide generalisation of the 1-bit compare cell
// TESTING  (WIDTH=16, DIGIT=4; run with and without the macro)
//  - a=0x1234 b=0x1234, unsigned -> eq=1.
//    Latency 4 in both builds.
//  - a=0x8000 b=0x7FFF: unsigned -> gt=1; signed -> lt=1.
//    Latency 1 with early exit, 4 without.
//  - a=0x1230 b=0x1231, unsigned -> lt=1.
//    Latency 4 in both builds (LSB digit differs).
//  - Backpressure: out_ready=0 for 5 cycles in DONE.
//    gt/eq/lt and out_valid stay stable; in_ready=0; a pulsed in_valid is not accepted.
//  - Reset mid-operation: rst_n low during SCAN.
//    Outputs go to 0 and in_ready to 1 asynchronously; the next op a=0xFFFF b=0x0001 signed gives lt=1.
//  - Back-to-back: in_valid and out_ready held high, 3 operand pairs.
//    Accepts are NDIG+2=6 cycles apart (no early exit); results arrive in order.

Source files
------------

// File: rtl/comparatore_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, the one-hot result encoding and the
// function that merges a sticky result with a newly compared digit.
package comparatore_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // One-hot result, bit order matches the {gt, eq, lt} output ports
   typedef enum logic [2:0] {
      GT = 3'b100,
      EQ = 3'b010,
      LT = 3'b001
   } cmp_res_t;

   // EQ means "no difference seen yet"; the first non-EQ digit wins and sticks
   function automatic cmp_res_t cmp_digit_res(input cmp_res_t sticky, input cmp_res_t digit);
      return (sticky != EQ) ? sticky : digit;
   endfunction

endpackage

// File: rtl/comparatore_digit.sv
// Combinational magnitude compare of one DIGIT-bit slice.
// This is the multi-bit form of the single-bit cell
// (gt = a & ~b, eq = ~(a ^ b), lt = ~a & b); outputs are one-hot.
module comparatore_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq,
   output logic             o_lt
);

   assign o_gt = (i_a >  i_b);
   assign o_eq = (i_a == i_b);
   assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/comparatore_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator, unsigned or two's-complement.
// Scans DIGIT bits per cycle from the MSB and returns a one-hot GT/EQ/LT
// behind valid/ready handshakes on both sides.
// Optional feature: define COMPARATORE_EARLY_EXIT_EN to end the scan on the
// first differing digit; otherwise the scan always takes NDIG cycles.
module comparatore_seq
   import comparatore_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             busy
);

   localparam int SAFE_DIGIT = (DIGIT < 1) ? 1 : DIGIT;
   localparam int NDIG       = WIDTH / SAFE_DIGIT;
   localparam int IDXW       = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   generate
      if (DIGIT < 1) begin : g_bad_digit
         $error("comparatore_seq: DIGIT must be at least 1");
      end else if ((WIDTH % SAFE_DIGIT) != 0) begin : g_bad_width
         $error("comparatore_seq: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDXW-1:0]  r_idx;
   cmp_res_t         r_res;
   logic [2:0]       r_out_res;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             r_busy;

   logic [SAFE_DIGIT-1:0] w_a_digs [NDIG];
   logic [SAFE_DIGIT-1:0] w_b_digs [NDIG];
   logic                  w_gt;
   logic                  w_eq;
   logic                  w_lt;
   cmp_res_t              w_next_res;
   logic                  w_scan_end;

   // Split the captured operands into digits so the scan can index them
   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_digits
         assign w_a_digs[gi] = r_a[gi*SAFE_DIGIT +: SAFE_DIGIT];
         assign w_b_digs[gi] = r_b[gi*SAFE_DIGIT +: SAFE_DIGIT];
      end
   endgenerate

   comparatore_digit #(
      .DIGIT (SAFE_DIGIT)
   ) u_digit (
      .i_a  (w_a_digs[r_idx]),
      .i_b  (w_b_digs[r_idx]),
      .o_gt (w_gt),
      .o_eq (w_eq),
      .o_lt (w_lt)
   );

   assign w_next_res = cmp_digit_res(r_res, cmp_res_t'({w_gt, w_eq, w_lt}));

`ifdef COMPARATORE_EARLY_EXIT_EN
   assign w_scan_end = (r_idx == '0) || (w_next_res != EQ);
`else
   assign w_scan_end = (r_idx == '0);
`endif

   // Control FSM: capture in IDLE, one digit per cycle in SCAN, hold result in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= IDX_TOP;
         r_res       <= EQ;
         r_out_res   <= 3'b000;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  // Flipping the sign bit maps two's-complement onto offset binary,
                  // so the unsigned digit scan yields the signed order
                  r_a        <= a ^ ({WIDTH{signed_mode}} & MSB_MASK);
                  r_b        <= b ^ ({WIDTH{signed_mode}} & MSB_MASK);
                  r_idx      <= IDX_TOP;
                  r_res      <= EQ;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= SCAN;
               end
            end
            SCAN: begin
               r_res <= w_next_res;
               r_idx <= r_idx - IDXW'(1);
               if (w_scan_end) begin
                  r_out_res   <= w_next_res;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (r_out_valid && out_ready) begin
                  r_out_res   <= 3'b000;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_idx       <= IDX_TOP;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign {gt, eq, lt} = r_out_res;
   assign busy         = r_busy;

endmodule

// File: tb/tb_comparatore_seq.sv
// Self-checking bench for comparatore_seq (WIDTH=16, DIGIT=4).
// Expected results and latencies come from a behavioural model and are queued
// when an operation is launched, then popped when the DUT presents a result.
// Latency expectations follow COMPARATORE_EARLY_EXIT_EN when it is defined.
module tb_comparatore_seq;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int NDIG  = WIDTH / DIGIT;

   typedef struct {
      logic [2:0] res;
      int         lat;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             gt;
   logic             eq;
   logic             lt;
   logic             busy;

   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   comparatore_seq #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .gt          (gt),
      .eq          (eq),
      .lt          (lt),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   // Reference compare using native signed/unsigned operators
   function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm);
      if (sm) begin
         if ($signed(x) > $signed(y)) return 3'b100;
         if ($signed(x) < $signed(y)) return 3'b001;
         return 3'b010;
      end
      if (x > y) return 3'b100;
      if (x < y) return 3'b001;
      return 3'b010;
   endfunction

   // Expected cycles from accept edge to out_valid
   function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] diff;
      diff = x ^ y;
`ifdef COMPARATORE_EARLY_EXIT_EN
      for (int j = 1; j <= NDIG; j++) begin
         if (diff[WIDTH - DIGIT*j +: DIGIT] != '0) return j;
      end
      return NDIG;
`else
      if (diff == '0) return NDIG;
      return NDIG;
`endif
   endfunction

   function automatic exp_t make_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm);
      exp_t e;
      e.res = model_res(x, y, sm);
      e.lat = model_lat(x, y);
      return e;
   endfunction

   // Launch one operation from IDLE and wait (bounded) for out_valid
   task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic sm,
                         output logic [2:0] res, output int lat, output bit timeout);
      @(negedge clk);
      a = ia; b = ib; signed_mode = sm; in_valid = 1'b1;
      @(posedge clk);
      #1;
      // Scramble inputs after the accept edge; the captured values must be used
      in_valid = 1'b0; a = ~ia; b = ib ^ 16'h5A5A; signed_mode = ~sm;
      lat = 0;
      timeout = 1'b0;
      while (!out_valid) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat > 40) begin
            timeout = 1'b1;
            break;
         end
      end
      res = {gt, eq, lt};
      $display("op a=%h b=%h signed=%b -> gt/eq/lt=%b latency=%0d", ia, ib, sm, res, lat);
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // Push expectation, run, pop and compare result and latency
   task automatic op_and_check(input string name, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic sm);
      logic [2:0] res;
      int         lat;
      bit         to;
      exp_t       e;
      sb.push_back(make_exp(ia, ib, sm));
      run_op(ia, ib, sm, res, lat, to);
      e = sb.pop_front();
      n_checks++;
      if (to) begin
         n_errors++;
         $display("FAIL %s_timeout: out_valid never rose, required within %0d cycles", name, e.lat);
      end
      n_checks++;
      if (res !== e.res) begin
         n_errors++;
         $display("FAIL %s_result: got %b required %b", name, res, e.res);
      end
      n_checks++;
      if (lat != e.lat) begin
         n_errors++;
         $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, gt, eq, lt, busy} !== 6'b100000) begin
         n_errors++;
         $display("FAIL reset_state: got in_ready/out_valid/gt/eq/lt/busy=%b required 100000",
                  {in_ready, out_valid, gt, eq, lt, busy});
      end
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_eq();
      op_and_check("eq_1234", 16'h1234, 16'h1234, 1'b0);
      n_checks++;
      if ({in_ready, busy} !== 2'b01) begin
         n_errors++;
         $display("FAIL done_flags: got in_ready/busy=%b required 01", {in_ready, busy});
      end
      release_result();
      n_checks++;
      if ({out_valid, gt, eq, lt, in_ready, busy} !== 6'b000010) begin
         n_errors++;
         $display("FAIL release_state: got out_valid/gt/eq/lt/in_ready/busy=%b required 000010",
                  {out_valid, gt, eq, lt, in_ready, busy});
      end
   endtask

   task automatic test_msb();
      op_and_check("msb_unsigned", 16'h8000, 16'h7FFF, 1'b0);
      release_result();
      op_and_check("msb_signed", 16'h8000, 16'h7FFF, 1'b1);
      release_result();
   endtask

   task automatic test_lsb();
      op_and_check("lsb_digit", 16'h1230, 16'h1231, 1'b0);
      release_result();
      op_and_check("lsb_signed_neg", 16'hFFF2, 16'hFFF1, 1'b1);
      release_result();
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             sm;
      for (int i = 0; i < 8; i++) begin
         x  = WIDTH'($urandom_range(16'hFFFF, 0));
         y  = x ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
         sm = 1'($urandom_range(1, 0));
         op_and_check("random", x, y, sm);
         release_result();
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      e = make_exp(16'h00F0, 16'h0F00, 1'b0);
      op_and_check("bp_op", 16'h00F0, 16'h0F00, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, gt, eq, lt, in_ready} !== {1'b1, e.res, 1'b0}) begin
            n_errors++;
            $display("FAIL bp_hold_%0d: got out_valid/gt/eq/lt/in_ready=%b required %b",
                     c, {out_valid, gt, eq, lt, in_ready}, {1'b1, e.res, 1'b0});
         end
         if (c == 2) begin
            a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      release_result();
      n_checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_errors++;
         $display("FAIL bp_no_accept: got out_valid/in_ready/busy=%b required 010", {out_valid, in_ready, busy});
      end
      $display("backpressure: 5 stalled cycles, pulsed in_valid ignored");
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_busy: got %b required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, gt, eq, lt, busy} !== 6'b100000) begin
         n_errors++;
         $display("FAIL mid_async_reset: got in_ready/out_valid/gt/eq/lt/busy=%b required 100000",
                  {in_ready, out_valid, gt, eq, lt, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_errors++;
         $display("FAIL mid_aborted: got out_valid=1 after abort required 0");
      end
      $display("reset during SCAN: operation aborted");
      op_and_check("after_reset", 16'hFFFF, 16'h0001, 1'b1);
      release_result();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] pa [3];
      logic [WIDTH-1:0] pb [3];
      logic             ps [3];
      int               acc_cyc [3];
      int               lat_exp [3];
      int               p;
      int               got;
      int               ncyc;
      bit               acc;
      exp_t             e;
      pa[0] = 16'h1234; pb[0] = 16'h1234; ps[0] = 1'b0;
      pa[1] = 16'h8000; pb[1] = 16'h7FFF; ps[1] = 1'b1;
      pa[2] = 16'hABCD; pb[2] = 16'hABCE; ps[2] = 1'b0;
      p = 0; got = 0; ncyc = 0;
      @(negedge clk);
      a = pa[0]; b = pb[0]; signed_mode = ps[0]; in_valid = 1'b1; out_ready = 1'b1;
      while ((got < 3) && (ncyc < 200)) begin
         acc = in_valid && in_ready;
         if (out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL b2b_extra: got unexpected result %b required none", {gt, eq, lt});
            end else begin
               e = sb.pop_front();
               if ({gt, eq, lt} !== e.res) begin
                  n_errors++;
                  $display("FAIL b2b_result_%0d: got %b required %b", got, {gt, eq, lt}, e.res);
               end
            end
            $display("b2b result %0d: gt/eq/lt=%b at cycle %0d", got, {gt, eq, lt}, ncyc);
            got++;
         end
         if (acc && p < 3) begin
            sb.push_back(make_exp(pa[p], pb[p], ps[p]));
            lat_exp[p] = model_lat(pa[p], pb[p]);
            acc_cyc[p] = ncyc;
            p++;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            if (p < 3) begin
               a = pa[p]; b = pb[p]; signed_mode = ps[p];
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         ncyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (got != 3 || p != 3) begin
         n_errors++;
         $display("FAIL b2b_count: got accepts=%0d results=%0d required 3 and 3", p, got);
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (acc_cyc[i+1] - acc_cyc[i] != lat_exp[i] + 2) begin
               n_errors++;
               $display("FAIL b2b_spacing_%0d: got %0d cycles required %0d",
                        i, acc_cyc[i+1] - acc_cyc[i], lat_exp[i] + 2);
            end
         end
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      a           = '0;
      b           = '0;
      signed_mode = 1'b0;
      test_reset();
      test_eq();
      test_msb();
      test_lsb();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
